// File: rtl/apu_pulse_regs.sv
// NES-style pulse register front end: byte writes in,
// duty and period transactions out through one-entry slots.
module apu_pulse_regs #(
  parameter bit          EMIT_ON_LOW = 1'b0,
  parameter logic [10:0] PERIOD_INIT = 11'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  apu__reg_addr,
  input  logic [7:0]  apu__reg_data,
  input  logic        apu__reg_vld,
  output logic        apu__reg_rdy,
  output logic [1:0]  apu__duty_s,
  output logic        apu__duty_s_vld,
  input  logic        apu__duty_s_rdy,
  output logic [10:0] apu__period_s,
  output logic        apu__period_s_vld,
  input  logic        apu__period_s_rdy,
  output logic [10:0] period_shadow
);

  logic [1:0]  duty_q, duty_d;
  logic        duty_vld_q, duty_vld_d;
  logic [10:0] per_q, per_d;
  logic        per_vld_q, per_vld_d;
  logic [10:0] shadow_q, shadow_d;

  logic        wr_duty, wr_lo, wr_hi, emit_per;
  logic        can_duty, can_per, slot_ok, acc;
  logic        ld_duty, ld_per;
  logic [10:0] per_new;

  always_comb begin
    wr_duty  = (apu__reg_addr == 2'd0);
    wr_lo    = (apu__reg_addr == 2'd2);
    wr_hi    = (apu__reg_addr == 2'd3);
    emit_per = wr_hi | (EMIT_ON_LOW & wr_lo);

    // A draining slot can take a new value in the same cycle.
    can_duty = ~duty_vld_q | apu__duty_s_rdy;
    can_per  = ~per_vld_q | apu__period_s_rdy;

    slot_ok = 1'b1;
    unique case (1'b1)
      wr_duty:  slot_ok = can_duty;
      emit_per: slot_ok = can_per;
      default:  slot_ok = 1'b1;
    endcase

    apu__reg_rdy = reset & apu__reg_vld & slot_ok;
    acc          = apu__reg_vld & apu__reg_rdy;

    shadow_d = shadow_q;
    if (acc && wr_lo) shadow_d[7:0]  = apu__reg_data;
    if (acc && wr_hi) shadow_d[10:8] = apu__reg_data[2:0];

    per_new = wr_hi ? {apu__reg_data[2:0], shadow_q[7:0]}
                    : {shadow_q[10:8], apu__reg_data};

    ld_duty = acc & wr_duty;
    ld_per  = acc & emit_per;

    duty_vld_d = ld_duty | (duty_vld_q & ~apu__duty_s_rdy);
    duty_d     = ld_duty ? apu__reg_data[7:6] : duty_q;
    per_vld_d  = ld_per | (per_vld_q & ~apu__period_s_rdy);
    per_d      = ld_per ? per_new : per_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q     <= 2'd0;
      duty_vld_q <= 1'b0;
      per_q      <= 11'd0;
      per_vld_q  <= 1'b0;
      shadow_q   <= PERIOD_INIT;
    end else begin
      duty_q     <= duty_d;
      duty_vld_q <= duty_vld_d;
      per_q      <= per_d;
      per_vld_q  <= per_vld_d;
      shadow_q   <= shadow_d;
    end
  end

  assign apu__duty_s       = duty_q;
  assign apu__duty_s_vld   = duty_vld_q;
  assign apu__period_s     = per_q;
  assign apu__period_s_vld = per_vld_q;
  assign period_shadow     = shadow_q;

endmodule

// File: tb/tb_apu_pulse_regs.sv
// Directed bench for apu_pulse_regs: per-cycle model compare
// plus literal checks, on a default and an EMIT_ON_LOW instance.
module tb_apu_pulse_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  data = 8'd0;
  logic        vld0 = 1'b0, vld1 = 1'b0;
  logic        duty_rdy = 1'b0, per_rdy = 1'b0;

  logic        rdy0, rdy1;
  logic [1:0]  duty0, duty1;
  logic        dvld0, dvld1;
  logic [10:0] per0, per1;
  logic        pvld0, pvld1;
  logic [10:0] sh0, sh1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apu_pulse_regs u_dut0 (
    .clk(clk), .reset(rst_n),
    .apu__reg_addr(addr), .apu__reg_data(data),
    .apu__reg_vld(vld0), .apu__reg_rdy(rdy0),
    .apu__duty_s(duty0), .apu__duty_s_vld(dvld0),
    .apu__duty_s_rdy(duty_rdy),
    .apu__period_s(per0), .apu__period_s_vld(pvld0),
    .apu__period_s_rdy(per_rdy),
    .period_shadow(sh0)
  );

  apu_pulse_regs #(
    .EMIT_ON_LOW(1'b1), .PERIOD_INIT(11'h700)
  ) u_dut1 (
    .clk(clk), .reset(rst_n),
    .apu__reg_addr(addr), .apu__reg_data(data),
    .apu__reg_vld(vld1), .apu__reg_rdy(rdy1),
    .apu__duty_s(duty1), .apu__duty_s_vld(dvld1),
    .apu__duty_s_rdy(duty_rdy),
    .apu__period_s(per1), .apu__period_s_vld(pvld1),
    .apu__period_s_rdy(per_rdy),
    .period_shadow(sh1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each slot is "occupied + value"; shadow is a plain number.
  int unsigned m_sh[2];
  bit          m_dfull[2], m_pfull[2];
  int unsigned m_dval[2], m_pval[2];
  int unsigned m_init[2] = '{32'h000, 32'h700};

  function automatic bit m_rdy(input int i);
    bit v;
    v = (i == 0) ? vld0 : vld1;
    if (!rst_n || !v) return 0;
    if (addr == 0) return !m_dfull[i] || duty_rdy;
    if (addr == 3 || (addr == 2 && i == 1))
      return !m_pfull[i] || per_rdy;
    return 1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_sh[i] = m_init[i];
      m_dfull[i] = 0;
      m_pfull[i] = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        for (int i = 0; i < 2; i++) begin
          bit acc;
          acc = m_rdy(i);
          if (m_dfull[i] && duty_rdy) m_dfull[i] = 0;
          if (m_pfull[i] && per_rdy) m_pfull[i] = 0;
          if (acc) begin
            if (addr == 0) begin
              m_dfull[i] = 1;
              m_dval[i] = data / 64;
            end else if (addr == 2) begin
              m_sh[i] = (m_sh[i] & 32'h700) | data;
              if (i == 1) begin
                m_pfull[i] = 1;
                m_pval[i] = m_sh[i];
              end
            end else if (addr == 3) begin
              m_sh[i] = (m_sh[i] & 32'hFF) | ((data % 8) * 256);
              m_pfull[i] = 1;
              m_pval[i] = m_sh[i];
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_rdy0", rdy0, m_rdy(0));
      chk("m_rdy1", rdy1, m_rdy(1));
      chk("m_dvld0", dvld0, m_dfull[0]);
      chk("m_dvld1", dvld1, m_dfull[1]);
      chk("m_pvld0", pvld0, m_pfull[0]);
      chk("m_pvld1", pvld1, m_pfull[1]);
      chk("m_sh0", sh0, m_sh[0]);
      chk("m_sh1", sh1, m_sh[1]);
      if (m_dfull[0]) chk("m_duty0", duty0, m_dval[0]);
      if (m_dfull[1]) chk("m_duty1", duty1, m_dval[1]);
      if (m_pfull[0]) chk("m_per0", per0, m_pval[0]);
      if (m_pfull[1]) chk("m_per1", per1, m_pval[1]);
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic do_write(input int inst, input logic [1:0] a,
                          input logic [7:0] d, input int maxc);
    bit ok;
    ok = 0;
    addr = a;
    data = d;
    if (inst == 0) vld0 = 1'b1;
    else vld1 = 1'b1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if ((inst == 0) ? rdy0 : rdy1) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_timeout: got rdy 0 expected 1 (addr %0d)", a);
    end
    @(posedge clk);
    #1;
    vld0 = 1'b0;
    vld1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vld0 = 1'b1;
    #12;
    chk("reset_rdy", rdy0, 0);
    chk("reset_pvld", pvld0, 0);
    chk("reset_sh1", sh1, 11'h700);
    vld0 = 1'b0;
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    per_rdy = 1'b1;
    do_write(0, 2'd2, 8'hA5, 4);
    @(negedge clk);
    chk("lo_no_emit", pvld0, 0);
    chk("lo_shadow", sh0, 11'h0A5);
    @(posedge clk);
    #1;
    do_write(0, 2'd3, 8'hFB, 4);
    @(negedge clk);
    chk("hi_per", per0, 11'h3A5);
    chk("hi_vld", pvld0, 1);
    @(negedge clk);
    chk("hi_vld_once", pvld0, 0);
    @(posedge clk);
    #1;

    duty_rdy = 1'b1;
    do_write(0, 2'd0, 8'hC3, 4);
    @(negedge clk);
    chk("duty_val", duty0, 2'b11);
    chk("duty_vld", dvld0, 1);
    @(negedge clk);
    chk("duty_vld_once", dvld0, 0);
    @(posedge clk);
    #1;
    do_write(0, 2'd1, 8'hFF, 2);
    @(negedge clk);
    chk("sweep_no_duty", dvld0, 0);
    chk("sweep_no_per", pvld0, 0);
    @(posedge clk);
    #1;

    per_rdy = 1'b0;
    do_write(0, 2'd3, 8'h01, 4);
    addr = 2'd3;
    data = 8'h02;
    vld0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_rdy", rdy0, 0);
      chk("bp_hold_per", per0, 11'h1A5);
      @(posedge clk);
      #1;
    end
    per_rdy = 1'b1;
    @(negedge clk);
    chk("bp_pulse_rdy", rdy0, 1);
    @(posedge clk);
    #1;
    vld0 = 1'b0;
    per_rdy = 1'b0;
    @(negedge clk);
    chk("bp_new_per", per0, 11'h2A5);
    chk("bp_vld_kept", pvld0, 1);
    @(posedge clk);
    #1;

    duty_rdy = 1'b0;
    addr = 2'd0;
    data = 8'h40;
    vld0 = 1'b1;
    @(negedge clk);
    chk("indep_rdy", rdy0, 1);
    @(posedge clk);
    #1;
    vld0 = 1'b0;
    @(negedge clk);
    chk("indep_duty", duty0, 2'b01);
    chk("indep_pfull", pvld0, 1);
    @(posedge clk);
    #1;
    duty_rdy = 1'b1;

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pvld", pvld0, 0);
    chk("arst_dvld", dvld0, 0);
    chk("arst_sh", sh0, 11'h000);
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_no_replay", pvld0, 0);
    end
    @(posedge clk);
    #1;

    do_write(1, 2'd2, 8'h12, 4);
    @(negedge clk);
    chk("low_emit_per", per1, 11'h712);
    chk("low_emit_vld", pvld1, 1);
    chk("low_emit_sh", sh1, 11'h712);
    @(posedge clk);
    #1;
    per_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
